irq_pending_controller: RTL and testbench

Sequential front end for the 4-to-2 priority encoder. It synchronises four asynchronous request lines, captures rising edges into a pending register and drives the masked pending bits into the encoder's I0..I3. It then reads back the encoder's Y/V outputs and runs a request / acknowledge / end-of-service handshake toward a consumer. Line 3 has the highest priority; priority resolution itself stays in the encoder.

---
 rtl/irq_pending_controller.sv | 96 +++++++++
 tb/tb_irq_pending_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_controller.sv
// Interrupt front end: synchronises request lines, latches rising edges as pending bits,
// feeds an external 4-to-2 priority encoder and runs the irq / ack / eoi handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | nothing offered; waits for the encoder to report a line
// ASSERT  | irq high, irq_id tracks the highest visible line
// SERVICE | line acked and cleared; busy until end-of-service
module irq_pending_controller #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in_i,
    input  logic [3:0] mask_i,
    output logic [3:0] pending_o,
    input  logic [1:0] enc_y_i,
    input  logic       enc_v_i,
    output logic       irq_o,
    output logic [1:0] irq_id_o,
    input  logic       ack_i,
    input  logic       eoi_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // sync_q[0] is the first stage; sync_q[SYNC_STAGES-1] is the synchronised level
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  prev_q;
    logic [3:0]                  pend_q, pend_d;
    logic [3:0]                  rise;
    logic [3:0]                  clr;
    state_e                      state_q, state_d;
    logic [1:0]                  id_q, id_d;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            id_q    <= 2'b00;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_in_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (enc_v_i) begin
                    id_d    = enc_y_i;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_i) begin
                    clr[id_q] = 1'b1;
                    state_d   = SERVICE;
                end else if (enc_v_i) begin
                    id_d = enc_y_i;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // OR-ing rise last keeps an edge that lands on the same cycle as its own ack
        pend_d = (pend_q & ~clr) | rise;
    end

    assign pending_o = pend_q & ~mask_i;
    assign irq_o     = (state_q == ASSERT);
    assign busy_o    = (state_q == SERVICE);
    assign irq_id_o  = id_q;

endmodule

// File: tb/tb_irq_pending_controller.sv
// Directed bench for irq_pending_controller with a behavioural reference model
// and a bench-side priority encoder closing the pending -> enc_y/enc_v loop.
module tb_irq_pending_controller;

    localparam int S = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic [3:0] pending;
    logic [1:0] enc_y;
    logic       enc_v;
    logic       irq;
    logic [1:0] irq_id;
    logic       ack;
    logic       eoi;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_pending_controller #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in_i (req_in),
        .mask_i   (mask),
        .pending_o(pending),
        .enc_y_i  (enc_y),
        .enc_v_i  (enc_v),
        .irq_o    (irq),
        .irq_id_o (irq_id),
        .ack_i    (ack),
        .eoi_i    (eoi),
        .busy_o   (busy)
    );

    // 4-to-2 priority encoder, line 3 highest
    always_comb begin
        enc_v = |pending;
        enc_y = 2'd0;
        if (pending[3])      enc_y = 2'd3;
        else if (pending[2]) enc_y = 2'd2;
        else if (pending[1]) enc_y = 2'd1;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: history of sampled request levels, pending set, and a
    // simple offered / in-service view of the handshake.
    logic [3:0] h [0:S];
    logic [3:0] m_pend;
    logic       m_offer;
    logic       m_serv;
    logic [1:0] m_id;

    always @(posedge clk or negedge rst_n) begin : model_p
        logic [3:0] rise_m;
        logic [3:0] vis;
        logic [3:0] np;
        logic [1:0] top;
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) h[i] <= '0;
            m_pend  <= '0;
            m_offer <= 1'b0;
            m_serv  <= 1'b0;
            m_id    <= 2'd0;
        end else begin
            rise_m = h[S-1] & ~h[S];
            vis    = m_pend & ~mask;
            top    = 2'd0;
            for (int k = 0; k < 4; k++) if (vis[k]) top = 2'(k);
            np = m_pend;
            if (m_serv) begin
                if (eoi) m_serv <= 1'b0;
            end else if (m_offer) begin
                if (ack) begin
                    np[m_id] = 1'b0;
                    m_serv   <= 1'b1;
                    m_offer  <= 1'b0;
                end else if (vis != 4'd0) begin
                    m_id <= top;
                end else begin
                    m_offer <= 1'b0;
                end
            end else if (vis != 4'd0) begin
                m_offer <= 1'b1;
                m_id    <= top;
            end
            m_pend <= np | rise_m;
            h[0]   <= req_in;
            for (int i = 1; i <= S; i++) h[i] <= h[i-1];
        end
    end

    always @(negedge clk) begin
        chk("model_pending", pending, m_pend & ~mask);
        chk("model_irq", 4'(irq), 4'(m_offer));
        chk("model_busy", 4'(busy), 4'(m_serv));
        chk("model_irq_id", 4'(irq_id), 4'(m_id));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(1); eoi = 1'b0;
    endtask

    initial begin
        req_in = 4'd0; mask = 4'd0; ack = 1'b0; eoi = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_irq", 4'(irq), 4'd0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_id", 4'(irq_id), 4'd0);
        chk("rst_pending", pending, 4'd0);
        tick(3);
        rst_n = 1'b1;

        // single request on line 2
        tick(1);
        req_in = 4'b0100;
        tick(2);
        chk("t1_pend_e2", pending, 4'b0000);
        tick(1);
        req_in = 4'b0000;
        chk("t1_pend_e3", pending, 4'b0100);
        chk("t1_irq_e3", 4'(irq), 4'd0);
        tick(1);
        chk("t1_irq_e4", 4'(irq), 4'd1);
        chk("t1_id_e4", 4'(irq_id), 4'd2);
        pulse_ack();
        chk("t1_busy", 4'(busy), 4'd1);
        chk("t1_irq_ack", 4'(irq), 4'd0);
        chk("t1_pend_ack", pending, 4'd0);
        pulse_eoi();
        chk("t1_busy_eoi", 4'(busy), 4'd0);
        chk("t1_irq_eoi", 4'(irq), 4'd0);
        ack = 1'b1; eoi = 1'b1; tick(1); ack = 1'b0; eoi = 1'b0;
        chk("t1_stray_busy", 4'(busy), 4'd0);
        chk("t1_stray_irq", 4'(irq), 4'd0);

        // priority tracking while asserted
        req_in = 4'b0010;
        tick(4);
        chk("t2_irq", 4'(irq), 4'd1);
        chk("t2_id1", 4'(irq_id), 4'd1);
        req_in = 4'b1010;
        tick(3);
        chk("t2_id_before", 4'(irq_id), 4'd1);
        tick(1);
        chk("t2_id3", 4'(irq_id), 4'd3);
        pulse_ack();
        chk("t2_pend_ack", pending, 4'b0010);
        chk("t2_busy", 4'(busy), 4'd1);
        chk("t2_id_frozen", 4'(irq_id), 4'd3);
        pulse_eoi();
        chk("t2_irq_eoi", 4'(irq), 4'd0);
        tick(1);
        chk("t2_reoffer_irq", 4'(irq), 4'd1);
        chk("t2_reoffer_id", 4'(irq_id), 4'd1);
        pulse_ack();
        pulse_eoi();
        req_in = 4'b0000;
        tick(3);

        // masking
        mask = 4'b0100;
        req_in = 4'b0101;
        tick(4);
        chk("t3_irq", 4'(irq), 4'd1);
        chk("t3_id0", 4'(irq_id), 4'd0);
        mask = 4'b0101;
        #1;
        chk("t3_pend_masked", pending, 4'b0000);
        tick(1);
        chk("t3_irq_idle", 4'(irq), 4'd0);
        chk("t3_id_held", 4'(irq_id), 4'd0);
        mask = 4'b0000;
        #1;
        chk("t3_pend_unmask", pending, 4'b0101);
        tick(1);
        chk("t3_irq2", 4'(irq), 4'd1);
        chk("t3_id2", 4'(irq_id), 4'd2);
        pulse_ack();
        chk("t3_pend_ack", pending, 4'b0001);
        pulse_eoi();
        tick(1);
        chk("t3_id0_again", 4'(irq_id), 4'd0);
        pulse_ack();
        pulse_eoi();
        req_in = 4'b0000;
        tick(3);

        // set and clear of line 2 on the same edge
        req_in = 4'b0100;
        tick(2);
        req_in = 4'b0000;
        tick(2);
        chk("t4_irq", 4'(irq), 4'd1);
        chk("t4_id", 4'(irq_id), 4'd2);
        req_in = 4'b0100;
        tick(2);
        pulse_ack();
        chk("t4_pend_kept", pending, 4'b0100);
        chk("t4_busy", 4'(busy), 4'd1);
        pulse_eoi();
        chk("t4_irq_eoi", 4'(irq), 4'd0);
        tick(1);
        chk("t4_reoffer_irq", 4'(irq), 4'd1);
        chk("t4_reoffer_id", 4'(irq_id), 4'd2);
        pulse_ack();
        pulse_eoi();
        req_in = 4'b0000;
        tick(3);

        // level held high: one service only
        req_in = 4'b0010;
        tick(4);
        chk("t5_irq", 4'(irq), 4'd1);
        pulse_ack();
        pulse_eoi();
        tick(14);
        chk("t5_level_irq", 4'(irq), 4'd0);
        chk("t5_level_pend", pending, 4'd0);
        req_in = 4'b0000;
        tick(2);

        // two edges on line 0 before ack: absorbed
        req_in = 4'b0001;
        tick(2);
        req_in = 4'b0000;
        tick(2);
        chk("t5_abs_id", 4'(irq_id), 4'd0);
        req_in = 4'b0001;
        tick(2);
        req_in = 4'b0000;
        tick(2);
        chk("t5_abs_pend", pending, 4'b0001);
        pulse_ack();
        chk("t5_abs_clr", pending, 4'd0);
        pulse_eoi();
        tick(6);
        chk("t5_abs_irq", 4'(irq), 4'd0);

        // reset in service, request held through release
        req_in = 4'b1000;
        tick(4);
        chk("t6_id3", 4'(irq_id), 4'd3);
        pulse_ack();
        chk("t6_busy", 4'(busy), 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 4'(busy), 4'd0);
        chk("t6_rst_irq", 4'(irq), 4'd0);
        chk("t6_rst_pend", pending, 4'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("t6_irq_e3", 4'(irq), 4'd0);
        tick(1);
        chk("t6_irq_e4", 4'(irq), 4'd1);
        chk("t6_id_e4", 4'(irq_id), 4'd3);
        pulse_ack();
        pulse_eoi();
        req_in = 4'b0000;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
